count_job_scheduler: RTL and testbench
======================================

Name: count_job_scheduler

Overview:
- Shares one busy/count_value counter (IDLE/START/COUNTING FSM, 5-bit count) among NUM_REQ requesters.
- Each requester asks for a count run of a given length.
- Round-robin arbitration picks one requester, then the block launches the counter, tracks busy, and returns a per-requester done pulse.
- Sits between the calibration/ranging sequencers and the shared counter.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- CNT_W, 5, counter length/count width
- TIMEOUT, 16, max cycles from cnt_start to cnt_busy rising before abort

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester request level; held until matching done
- req_len  in  NUM_REQ*CNT_W  requested run length, slice i = requester i
- gnt  out  NUM_REQ  one-hot one-cycle grant pulse
- done  out  NUM_REQ  one-hot one-cycle completion pulse
- cnt_start  out  1  one-cycle start pulse to counter
- cnt_len  out  CNT_W  latched length driven to counter; stable for whole job
- cnt_busy  in  1  counter busy
- cnt_count_value  in  CNT_W  counter value
- sched_busy  out  1  high in any state except IDLE
- active_id  out  $clog2(NUM_REQ)  index of granted requester; valid while sched_busy
- err_timeout  out  1  sticky; busy never rose within TIMEOUT
- err_mismatch  out  1  sticky; see Optional Feature

Behaviour:
- All outputs are registered.
- Reset values: gnt=0, done=0, cnt_start=0, cnt_len=0, sched_busy=0, active_id=0, err_*=0, rr pointer=0, state=IDLE.
- Reset mid-job aborts the job. No done is issued. cnt_start drops the next edge.
- States: IDLE, LAUNCH, WAIT_BUSY, RUN, DONE.
- IDLE:
  - If any req bit is set in cycle N, grant the first set bit at or after the rr pointer, wrapping.
  - Latch active_id and cnt_len=req_len[id].
  - Move the rr pointer to id+1 mod NUM_REQ.
  - Go to LAUNCH.
- Zero-length request (req_len[id]==0):
  - Go to DONE instead of LAUNCH.
  - gnt pulses at N+1, done pulses at N+2.
  - No cnt_start.
- LAUNCH (cycle N+1):
  - gnt[id]=1 and cnt_start=1 for exactly this cycle.
  - Clear the timeout counter. Go to WAIT_BUSY.
- WAIT_BUSY:
  - cnt_busy=1 → RUN.
  - Otherwise increment the timeout counter.
  - When the count reaches TIMEOUT, set err_timeout and go to DONE; the requester still gets done.
- RUN:
  - Stay while cnt_busy=1.
  - First cycle cnt_busy=0 → capture cnt_count_value, go to DONE.
- DONE:
  - done[id]=1 for one cycle. Go to IDLE.
  - Earliest next gnt: 2 cycles after done (IDLE samples, LAUNCH grants).
- req deassert after gnt is ignored; the job runs to completion.
- req re-asserted by the same requester competes normally; round-robin prevents starvation.
- A requester asserting req while another job runs waits; no queue depth beyond the req level.
- Simultaneous requests with pointer=p: lowest index ≥p wins, else lowest index overall.
- cnt_start never asserts while sched_busy was already high from a previous job. One job at a time.
- err_timeout and err_mismatch clear only on rst.

Optional Feature:
- Macro: COUNT_JOB_CHECK_EN.
- Defined: in RUN→DONE, compare the captured cnt_count_value with cnt_len. On mismatch, set sticky err_mismatch (job still completes with done).
- Not defined: no comparator logic; err_mismatch tied to 0.

Test Plan:
- Single requester: req[0]=1, req_len[0]=5, counter busy 5 cycles → gnt[0] and cnt_start same cycle; cnt_len=5; done[0] one cycle after busy falls; sched_busy low after.
- Round-robin: req=4'b1111 all held → grant order 0,1,2,3,0; each done before next gnt.
- Zero length: req[2]=1, req_len[2]=0 → gnt[2] then done[2] next cycle; cnt_start never asserted.
- Timeout: counter model never raises busy, TIMEOUT=16 → err_timeout=1 exactly 16 cycles after WAIT_BUSY entry; done pulses; next request still served.
- Reset mid-RUN: rst high 1 cycle while busy → all outputs 0 next cycle, no done, pointer=0; next req[1] granted normally.
- With COUNT_JOB_CHECK_EN: req_len=7, counter ends at 6 → err_mismatch=1 and done still pulses. Without the macro: err_mismatch stays 0.

Source files
------------

// File: rtl/count_job_scheduler.sv
// count_job_scheduler: round-robin front end for one shared busy/count_value
// counter. Grants one requester at a time, launches the counter with the
// requester's length, watches busy and returns a one-cycle done pulse.
// Optional macro COUNT_JOB_CHECK_EN adds a final-count comparator that sets
// the sticky err_mismatch flag; without it err_mismatch is tied low.
module count_job_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 5,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*CNT_W-1:0]   req_len,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done,
  output logic                       cnt_start,
  output logic [CNT_W-1:0]           cnt_len,
  input  logic                       cnt_busy,
  input  logic [CNT_W-1:0]           cnt_count_value,
  output logic                       sched_busy,
  output logic [$clog2(NUM_REQ)-1:0] active_id,
  output logic                       err_timeout,
  output logic                       err_mismatch
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    RUN,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              found;
  logic [ID_W-1:0]   pick;
  logic [CNT_W-1:0]  pick_len;
  logic              timeout_hit;
  logic              done_fire;

  assign pick_len = req_len[pick*CNT_W +: CNT_W];

  // Round-robin pick: first set req bit at or after the pointer, wrapping.
  always_comb begin
    // NOTE: every variable written here gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    found = 1'b0;
    pick  = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[(int'(ptr_q) + i) % NUM_REQ]) begin
        found = 1'b1;
        pick  = ID_W'((int'(ptr_q) + i) % NUM_REQ);
      end
    end
  end

  // Next-state logic and the busy-wait timeout counter.
  always_comb begin
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    timeout_hit = 1'b0;
    done_fire   = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) state_d = (pick_len == '0) ? DONE : LAUNCH;
      end
      LAUNCH: begin
        to_cnt_d = '0;
        state_d  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (cnt_busy) begin
          state_d = RUN;
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          done_fire   = 1'b1;
          state_d     = DONE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!cnt_busy) begin
          done_fire = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        // A zero-length job enters DONE straight from IDLE with done still
        // low; it lingers one cycle so done follows gnt by a cycle.
        if (!done_q_any()) begin
          done_fire = 1'b1;
          state_d   = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  function automatic logic done_q_any();
    return |done;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous (sampled on the clock edge) and all state
    // updates use non-blocking assignments so every flop sees pre-edge values.
    if (rst) begin
      state_q  <= IDLE;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // Registered outputs, job context and the round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      gnt         <= '0;
      done        <= '0;
      cnt_start   <= 1'b0;
      cnt_len     <= '0;
      sched_busy  <= 1'b0;
      active_id   <= '0;
      err_timeout <= 1'b0;
    end else begin
      gnt        <= '0;
      done       <= '0;
      cnt_start  <= 1'b0;
      sched_busy <= (state_d != IDLE);
      if (state_q == IDLE && found) begin
        active_id <= pick;
        cnt_len   <= pick_len;
        ptr_q     <= ID_W'((int'(pick) + 1) % NUM_REQ);
        gnt       <= NUM_REQ'(1) << pick;
        cnt_start <= (pick_len != '0);
      end
      if (done_fire) done <= NUM_REQ'(1) << active_id;
      if (timeout_hit) err_timeout <= 1'b1;
    end
  end

`ifdef COUNT_JOB_CHECK_EN
  // Sticky flag: final counter value on the RUN->DONE edge differs from the
  // length this job was launched with.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_mismatch <= 1'b0;
    end else if (state_q == RUN && !cnt_busy && cnt_count_value != cnt_len) begin
      err_mismatch <= 1'b1;
    end
  end
`else
  logic unused_count_value;
  assign unused_count_value = ^cnt_count_value;
  assign err_mismatch       = 1'b0;
`endif

endmodule

// File: tb/tb_count_job_scheduler.sv
// tb_count_job_scheduler: directed scoreboard bench for count_job_scheduler.
// Stimulus pushes expected grant/done events into a queue; a monitor pops and
// compares whenever the DUT pulses gnt or done. A simple counter model answers
// cnt_start with a busy window of cnt_len cycles.
module tb_count_job_scheduler;

  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 5;
  localparam int TIMEOUT = 16;

  typedef enum int {M_NORMAL, M_DEAD, M_MISCOUNT} mode_t;

  typedef struct {
    bit         is_done;
    int         id;
    bit         start;
    int         len;
    int         gap;
    bit         err_to;
    bit         err_to_prev;
    bit         err_mm;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_REQ-1:0]       req = '0;
  logic [NUM_REQ*CNT_W-1:0] req_len = '0;
  logic [NUM_REQ-1:0]       gnt, done;
  logic                     cnt_start;
  logic [CNT_W-1:0]         cnt_len;
  logic                     cnt_busy = 1'b0;
  logic [CNT_W-1:0]         cnt_count_value = '0;
  logic                     sched_busy;
  logic [1:0]               active_id;
  logic                     err_timeout, err_mismatch;

  mode_t mode = M_NORMAL;
  int    rem = 0;
  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    last_gnt_cyc = 0;
  int    start_cnt = 0;
  bit    err_prev = 1'b0;
  bit    mm_exp;

  count_job_scheduler #(
    .NUM_REQ(NUM_REQ), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_len(req_len),
    .gnt(gnt), .done(done), .cnt_start(cnt_start), .cnt_len(cnt_len),
    .cnt_busy(cnt_busy), .cnt_count_value(cnt_count_value),
    .sched_busy(sched_busy), .active_id(active_id),
    .err_timeout(err_timeout), .err_mismatch(err_mismatch)
  );

  always #5 clk = ~clk;

  // Shared counter model: busy for cnt_len cycles, count_value ends at
  // cnt_len (one short in M_MISCOUNT, never busy in M_DEAD).
  always @(posedge clk) begin
    if (rst) begin
      cnt_busy        <= 1'b0;
      cnt_count_value <= '0;
      rem             <= 0;
    end else if (cnt_start && mode != M_DEAD) begin
      cnt_busy        <= 1'b1;
      cnt_count_value <= '0;
      rem             <= int'(cnt_len);
    end else if (cnt_busy) begin
      if (rem == 1) cnt_busy <= 1'b0;
      rem <= rem - 1;
      if (!(mode == M_MISCOUNT && rem == 1)) cnt_count_value <= cnt_count_value + 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic push_gnt(input int id, input int len);
    exp_t e;
    e = '{is_done: 1'b0, id: id, start: (len != 0), len: len, gap: 0,
          err_to: 1'b0, err_to_prev: 1'b0, err_mm: 1'b0};
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int id, input int gap, input bit eto, input bit eto_prev, input bit emm);
    exp_t e;
    e = '{is_done: 1'b1, id: id, start: 1'b0, len: 0, gap: gap,
          err_to: eto, err_to_prev: eto_prev, err_mm: emm};
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int id, input int len);
    req_len[id*CNT_W +: CNT_W] = CNT_W'(len);
    req[id] = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    req  = '0;
    mode = M_NORMAL;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drops each req bit on its done; returns on done[stop_id], or when idle
  // with no outstanding expectations if stop_id < 0.
  task automatic serve(input int budget, input int stop_id);
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (stop_id >= 0 && done[stop_id]) begin
        req = req & ~done;
        return;
      end
      req = req & ~done;
      if (stop_id < 0 && exp_q.size() == 0 && !sched_busy && req == '0) return;
      n++;
      if (n > budget) begin
        check("serve_budget_expired", 1, 0);
        return;
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (cnt_start) start_cnt++;
        if (cnt_start && gnt == '0) check("cnt_start_without_gnt", 1, 0);
        if (gnt != '0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_gnt", 32'(gnt), 0);
          end else begin
            e = exp_q.pop_front();
            check("gnt_kind", 32'(e.is_done), 0);
            check("gnt_vector", 32'(gnt), 32'(1) << e.id);
            check("gnt_active_id", 32'(active_id), 32'(e.id));
            check("gnt_cnt_start", 32'(cnt_start), 32'(e.start));
            check("gnt_cnt_len", 32'(cnt_len), 32'(e.len));
            check("gnt_sched_busy", 32'(sched_busy), 1);
            last_gnt_cyc = cyc;
          end
        end
        if (done != '0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 32'(done), 0);
          end else begin
            e = exp_q.pop_front();
            check("done_kind", 32'(e.is_done), 1);
            check("done_vector", 32'(done), 32'(1) << e.id);
            check("done_gap_from_gnt", 32'(cyc - last_gnt_cyc), 32'(e.gap));
            check("done_err_timeout", 32'(err_timeout), 32'(e.err_to));
            check("done_err_timeout_prev", 32'(err_prev), 32'(e.err_to_prev));
            check("done_err_mismatch", 32'(err_mismatch), 32'(e.err_mm));
          end
        end
        err_prev = err_timeout;
      end else begin
        err_prev = 1'b0;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_cnt_start"}, 32'(cnt_start), 0);
    check({tag, "_cnt_len"}, 32'(cnt_len), 0);
    check({tag, "_sched_busy"}, 32'(sched_busy), 0);
    check({tag, "_active_id"}, 32'(active_id), 0);
    check({tag, "_err_timeout"}, 32'(err_timeout), 0);
    check({tag, "_err_mismatch"}, 32'(err_mismatch), 0);
  endtask

  task automatic stimulus();
    int n;
    int starts_before;
`ifdef COUNT_JOB_CHECK_EN
    mm_exp = 1'b1;
`else
    mm_exp = 1'b0;
`endif
    // Reset state.
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Round robin from pointer 0: lengths 3,4,2,1, then requester 0 again.
    push_gnt(0, 3); push_done(0, 5, 0, 0, 0);
    push_gnt(1, 4); push_done(1, 6, 0, 0, 0);
    push_gnt(2, 2); push_done(2, 4, 0, 0, 0);
    push_gnt(3, 1); push_done(3, 3, 0, 0, 0);
    push_gnt(0, 6); push_done(0, 8, 0, 0, 0);
    @(negedge clk);
    set_req(0, 3); set_req(1, 4); set_req(2, 2); set_req(3, 1);
    serve(100, 0);
    set_req(0, 6);
    serve(200, -1);

    // Single requester, length 5.
    do_reset();
    push_gnt(0, 5); push_done(0, 7, 0, 0, 0);
    set_req(0, 5);
    serve(100, -1);
    @(negedge clk);
    check("single_idle_after", 32'(sched_busy), 0);
    check("single_done_after", 32'(done), 0);

    // Zero-length request: gnt then done next cycle, no counter start.
    starts_before = start_cnt;
    push_gnt(2, 0); push_done(2, 1, 0, 0, 0);
    @(negedge clk);
    set_req(2, 0);
    serve(50, -1);
    check("zero_len_no_cnt_start", 32'(start_cnt - starts_before), 0);

    // Timeout: counter never goes busy; requester 3 still gets done.
    mode = M_DEAD;
    push_gnt(3, 4); push_done(3, 17, 1, 0, 0);
    set_req(3, 4);
    serve(100, -1);
    mode = M_NORMAL;
    push_gnt(1, 2); push_done(1, 4, 1, 1, 0);
    set_req(1, 2);
    serve(100, -1);

    // Reset in the middle of RUN: no done, everything clear, pointer back to 0.
    push_gnt(2, 10);
    set_req(2, 10);
    n = 0;
    while (!cnt_busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("midrun_busy_seen", 32'(cnt_busy), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("midrun_reset");
    check("midrun_queue_drained", 32'(exp_q.size()), 0);
    push_gnt(1, 3); push_done(1, 5, 0, 0, 0);
    push_gnt(3, 2); push_done(3, 4, 0, 0, 0);
    set_req(1, 3); set_req(3, 2);
    serve(200, -1);

    // Final count one short of the requested length.
    mode = M_MISCOUNT;
    push_gnt(0, 7); push_done(0, 9, 0, 0, mm_exp);
    set_req(0, 7);
    serve(100, -1);
    @(negedge clk);
    check("mismatch_sticky", 32'(err_mismatch), 32'(mm_exp));
    check("final_queue_empty", 32'(exp_q.size()), 0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
      begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
